// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD countdown counter.
// Optional feature macro: BCD_COUNTDOWN_AUTORELOAD_EN (used by bcd_countdown).
package bcd_pkg;

  // One BCD decade.
  typedef logic [3:0] bcd_digit_t;

  // Largest legal value of a BCD decade.
  localparam bcd_digit_t BCD_MAX = 4'd9;

  // Counter control states.
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  // Clamp an arbitrary nibble to a legal BCD digit.
  function automatic bcd_digit_t bcd_sat(input logic [3:0] raw);
    return (raw > BCD_MAX) ? BCD_MAX : raw;
  endfunction

endpackage

// File: rtl/bcd_digit_dec.sv
// One decade of the BCD decrement chain: subtracts borrow_in from the digit,
// wrapping 0 -> 9 and passing a borrow to the next decade when it wraps.
module bcd_digit_dec
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       borrow_in,
  output bcd_digit_t digit_next,
  output logic       borrow_out
);

  // Decrement this decade when a borrow arrives; otherwise pass it through.
  always_comb begin
    digit_next = digit;
    borrow_out = 1'b0;
    if (borrow_in) begin
      if (digit == 4'd0) begin
        digit_next = BCD_MAX;
        borrow_out = 1'b1;
      end else begin
        digit_next = digit - 4'd1;
      end
    end
  end

endmodule

// File: rtl/bcd_countdown.sv
// Multi-decade BCD countdown counter with load, start, pause and tick strobes.
// All control inputs are single-cycle strobes except pause, which is a level.
// Optional feature macro: BCD_COUNTDOWN_AUTORELOAD_EN -- when defined, the
// counter reloads the last loaded value on reaching zero and keeps running
// if that value is nonzero.
module bcd_countdown
  import bcd_pkg::*;
#(
  parameter int NUM_DIGITS = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] load_value,
  input  logic                    start,
  input  logic                    pause,
  input  logic                    tick,
  output logic [4*NUM_DIGITS-1:0] digits,
  output logic                    busy,
  output logic                    done,
  output state_e                  dbg_state
);

  localparam int W = 4 * NUM_DIGITS;

  state_e         state_q, state_d;
  logic [W-1:0]   digits_q, digits_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;

  logic [W-1:0]   load_sat;
  logic [W-1:0]   dec_digits;
  logic [NUM_DIGITS:0] borrow;
  logic           reaches_zero;

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
  logic [W-1:0]   reload_q, reload_d;
`endif

  // The units decade always receives the borrow; the chain yields count-1.
  assign borrow[0] = 1'b1;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    bcd_digit_dec u_dec (
      .digit      (digits_q[4*g +: 4]),
      .borrow_in  (borrow[g]),
      .digit_next (dec_digits[4*g +: 4]),
      .borrow_out (borrow[g+1])
    );
  end

  // A borrow out of the top decade means the count was already zero; treat
  // it the same as reaching zero so the count can never wrap below zero.
  assign reaches_zero = (dec_digits == '0) || borrow[NUM_DIGITS];

  // Clamp every nibble of the load value to a legal BCD digit.
  always_comb begin
    load_sat = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      load_sat[4*i +: 4] = bcd_sat(load_value[4*i +: 4]);
    end
  end

  // Next-state logic: load wins over everything, then per-state behaviour.
  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    done_d   = 1'b0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    reload_d = reload_q;
`endif
    if (load) begin
      state_d  = ST_IDLE;
      digits_d = load_sat;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
      reload_d = load_sat;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            if (digits_q != '0) begin
              state_d = ST_RUN;
            end else begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (pause) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            if (reaches_zero) begin
              done_d = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
              digits_d = reload_q;
              state_d  = (reload_q != '0) ? ST_RUN : ST_IDLE;
`else
              digits_d = '0;
              state_d  = ST_DONE;
`endif
            end else begin
              digits_d = dec_digits;
            end
          end
        end
        ST_PAUSED: begin
          if (!pause) begin
            state_d = ST_RUN;
          end
        end
        ST_DONE: begin
          state_d = ST_IDLE;
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    busy_d = (state_d == ST_RUN) || (state_d == ST_PAUSED);
  end

  // Control and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      digits_q <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
      reload_q <= '0;
`endif
    end else begin
      state_q  <= state_d;
      digits_q <= digits_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
      reload_q <= reload_d;
`endif
    end
  end

  assign digits    = digits_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_bcd_countdown.sv
// Bench for bcd_countdown: directed vectors with literal expectations plus a
// decimal-arithmetic reference model compared against the DUT every cycle.
module tb_bcd_countdown;
  import bcd_pkg::*;

  localparam int ND = 4;
  localparam int W  = 4 * ND;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         load = 1'b0;
  logic [W-1:0] load_value = '0;
  logic         start = 1'b0;
  logic         pause = 1'b0;
  logic         tick = 1'b0;
  logic [W-1:0] digits;
  logic         busy;
  logic         done;
  state_e       dbg_state;

  always #5 clk = ~clk;

  bcd_countdown #(.NUM_DIGITS(ND)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .tick       (tick),
    .digits     (digits),
    .busy       (busy),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // The count is kept as a plain integer; BCD only appears at the compare.
  typedef struct {
    int count;
    int reload;
    bit running;
    bit paused;
    bit finishing;
    bit done;
  } model_t;

  function automatic int bcd_to_int_sat(input logic [W-1:0] v);
    int r;
    int n;
    r = 0;
    for (int i = ND - 1; i >= 0; i--) begin
      n = int'(v[4*i +: 4]);
      if (n > 9) n = 9;
      r = r * 10 + n;
    end
    return r;
  endfunction

  function automatic logic [W-1:0] int_to_bcd(input int x);
    logic [W-1:0] r;
    int v;
    r = '0;
    v = x;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic model_t model_step(input model_t m, input logic r, input logic l,
                                        input logic [W-1:0] lv, input logic s,
                                        input logic p, input logic t);
    model_t n;
    n = m;
    n.done = 1'b0;
    if (r) begin
      n.count = 0; n.reload = 0; n.running = 0; n.paused = 0; n.finishing = 0;
    end else if (l) begin
      n.count = bcd_to_int_sat(lv);
      n.reload = n.count;
      n.running = 0; n.paused = 0; n.finishing = 0;
    end else if (m.finishing) begin
      n.finishing = 0;
    end else if (m.paused) begin
      if (!p) begin n.paused = 0; n.running = 1; end
    end else if (m.running) begin
      if (p) begin
        n.paused = 1; n.running = 0;
      end else if (t) begin
        n.count = (m.count > 0) ? m.count - 1 : 0;
        if (n.count == 0) begin
          n.done = 1;
          if (AUTO) begin
            n.count = m.reload;
            n.running = (m.reload != 0);
          end else begin
            n.running = 0;
            n.finishing = 1;
          end
        end
      end
    end else if (s) begin
      if (m.count != 0) n.running = 1;
      else begin n.finishing = 1; n.done = 1; end
    end
    return n;
  endfunction

  model_t m;
  bit     model_live = 1'b0;

  // Advance the model on every active edge from the inputs the DUT sees.
  always @(posedge clk) begin
    m <= model_step(m, rst, load, load_value, start, pause, tick);
    model_live <= 1'b1;
  end

  // Compare DUT outputs against the model on the opposite edge.
  always @(negedge clk) begin
    if (model_live) begin
      check("model_digits", {16'h0, digits}, {16'h0, int_to_bcd(m.count)});
      check("model_busy", {31'h0, busy}, {31'h0, (m.running | m.paused)});
      check("model_done", {31'h0, done}, {31'h0, m.done});
    end
  end

  // ---------------- driver ----------------
  task automatic drive(input logic r, input logic l, input logic [W-1:0] lv,
                       input logic s, input logic p, input logic t);
    rst = r; load = l; load_value = lv; start = s; pause = p; tick = t;
    @(posedge clk);
    #1;
  endtask

  task automatic idle_cycle();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_load(input logic [W-1:0] v);
    drive(1'b0, 1'b1, v, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic do_start();
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b0);
  endtask

  task automatic do_tick();
    drive(1'b0, 1'b0, '0, 1'b0, 1'b0, 1'b1);
  endtask

  int done_seen;

  // ---------------- directed stimulus ----------------
  initial begin
    // Reset overrides a simultaneous load.
    drive(1'b1, 1'b1, 16'h1234, 1'b0, 1'b0, 1'b0);
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0, 1'b0);
    check("rst_digits", {16'h0, digits}, 32'h0);
    check("rst_busy", {31'h0, busy}, 32'h0);
    check("rst_done", {31'h0, done}, 32'h0);
    check("rst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});

    // Tick in IDLE is ignored.
    do_tick();
    check("idle_tick", {16'h0, digits}, 32'h0);

    // 0003: three ticks down to zero.
    do_load(16'h0003);
    check("ld3_digits", {16'h0, digits}, 32'h0003);
    check("ld3_busy", {31'h0, busy}, 32'h0);
    do_start();
    check("st3_busy", {31'h0, busy}, 32'h1);
    do_tick();
    check("t1_digits", {16'h0, digits}, 32'h0002);
    do_tick();
    check("t2_digits", {16'h0, digits}, 32'h0001);
    check("t2_done", {31'h0, done}, 32'h0);
    do_tick();
    check("t3_digits", {16'h0, digits}, AUTO ? 32'h0003 : 32'h0000);
    check("t3_done", {31'h0, done}, 32'h1);
    check("t3_busy", {31'h0, busy}, AUTO ? 32'h1 : 32'h0);
    idle_cycle();
    check("post3_done", {31'h0, done}, 32'h0);
    check("post3_busy", {31'h0, busy}, AUTO ? 32'h1 : 32'h0);

    // 1000: borrow ripples through three decades; load aborts the run.
    do_load(16'h1000);
    check("ld1000_done", {31'h0, done}, 32'h0);
    check("ld1000_busy", {31'h0, busy}, 32'h0);
    do_start();
    do_tick();
    check("t1000_digits", {16'h0, digits}, 32'h0999);
    drive(1'b0, 1'b0, '0, 1'b1, 1'b0, 1'b1);
    check("busy_start_ign", {16'h0, digits}, 32'h0998);
    check("busy_start_busy", {31'h0, busy}, 32'h1);
    do_load(16'h0042);
    check("abort_digits", {16'h0, digits}, 32'h0042);
    check("abort_done", {31'h0, done}, 32'h0);
    check("abort_busy", {31'h0, busy}, 32'h0);

    // 0000 start: straight to DONE with no decrement.
    do_load(16'h0000);
    do_start();
    check("z_done", {31'h0, done}, 32'h1);
    check("z_digits", {16'h0, digits}, 32'h0);
    check("z_busy", {31'h0, busy}, 32'h0);
    do_tick();
    check("z_done_off", {31'h0, done}, 32'h0);
    check("z_digits2", {16'h0, digits}, 32'h0);

    // 0050: five ticks, pause with ticks ignored, then resume.
    do_load(16'h0050);
    do_start();
    for (int i = 0; i < 5; i++) do_tick();
    check("p_before", {16'h0, digits}, 32'h0045);
    drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b0);
    check("p_busy", {31'h0, busy}, 32'h1);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b0, '0, 1'b0, 1'b1, 1'b1);
      check("p_hold", {16'h0, digits}, 32'h0045);
    end
    idle_cycle();
    check("p_release", {16'h0, digits}, 32'h0045);
    do_tick();
    check("p_resume", {16'h0, digits}, 32'h0044);

    // Reset mid-run aborts without done, even with load high.
    drive(1'b1, 1'b1, 16'h0077, 1'b0, 1'b0, 1'b1);
    check("midrst_digits", {16'h0, digits}, 32'h0);
    check("midrst_done", {31'h0, done}, 32'h0);
    check("midrst_busy", {31'h0, busy}, 32'h0);

    // Out-of-range nibble clamps; load beats start in the same cycle.
    do_load(16'h00F7);
    check("clamp_digits", {16'h0, digits}, 32'h0097);
    drive(1'b0, 1'b1, 16'h0012, 1'b1, 1'b0, 1'b0);
    check("ldst_digits", {16'h0, digits}, 32'h0012);
    check("ldst_busy", {31'h0, busy}, 32'h0);
    idle_cycle();
    check("ldst_busy2", {31'h0, busy}, 32'h0);
    check("ldst_state", {30'h0, dbg_state}, {30'h0, ST_IDLE});

    // Count 0012 all the way down through a decade boundary.
    do_start();
    for (int i = 0; i < 11; i++) do_tick();
    check("d12_last1", {16'h0, digits}, 32'h0001);
    do_tick();
    check("d12_zero", {16'h0, digits}, AUTO ? 32'h0012 : 32'h0000);
    check("d12_done", {31'h0, done}, 32'h1);

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    // Autoreload: 0002 with four ticks gives two done pulses.
    do_load(16'h0002);
    do_start();
    done_seen = 0;
    for (int i = 0; i < 4; i++) begin
      do_tick();
      if (done) begin
        done_seen++;
        check("ar_reload", {16'h0, digits}, 32'h0002);
      end
    end
    check("ar_pulses", done_seen, 32'd2);
    check("ar_busy", {31'h0, busy}, 32'h1);
`endif

    idle_cycle();
    idle_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
